// File: rtl/mem_loader.sv
// Memory-side front end: streams WORDS words into the shared memory, then releases
// the downstream core from reset and lends it the memory port until it reports Ready.
module mem_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int WORDS      = 32
) (
  input  logic                  Clock_i,
  input  logic                  Reset_i,
  input  logic                  Start_i,
  input  logic                  InValid_i,
  input  logic [DATA_WIDTH-1:0] InData_i,
  output logic                  InReady_o,
  output logic                  AccReset_o,
  input  logic                  AccReady_i,
  input  logic [ADDR_WIDTH-1:0] AccAddress_i,
  input  logic                  AccReadEnable_i,
  input  logic                  AccWriteEnable_i,
  input  logic [DATA_WIDTH-1:0] AccDataIN_i,
  output logic [ADDR_WIDTH-1:0] MemAddress_o,
  output logic                  MemReadEnable_o,
  output logic                  MemWriteEnable_o,
  output logic [DATA_WIDTH-1:0] MemDataIN_o,
  output logic [ADDR_WIDTH:0]   LoadCount_o,
  output logic                  Busy_o,
  output logic                  Done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  // Set after the first RUN cycle so AccReady is ignored while the core settles.
  logic                  settled_q, settled_d;

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      settled_q <= settled_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    settled_d        = 1'b0;
    InReady_o        = 1'b0;
    AccReset_o       = 1'b1;
    MemAddress_o     = '0;
    MemReadEnable_o  = 1'b0;
    MemWriteEnable_o = 1'b0;
    MemDataIN_o      = '0;
    Busy_o           = 1'b0;
    Done_o           = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        InReady_o = 1'b1;
        Busy_o    = 1'b1;
        if (InValid_i) begin
          MemWriteEnable_o = 1'b1;
          MemAddress_o     = count_q[ADDR_WIDTH-1:0];
          MemDataIN_o      = InData_i;
          count_d          = count_q + ONE;
          if (count_q == LAST_IDX) state_d = RUN;
        end
      end
      RUN: begin
        // The core owns the memory port outright; no registering on this path.
        AccReset_o       = 1'b0;
        Busy_o           = 1'b1;
        MemAddress_o     = AccAddress_i;
        MemReadEnable_o  = AccReadEnable_i;
        MemWriteEnable_o = AccWriteEnable_i;
        MemDataIN_o      = AccDataIN_i;
        settled_d        = 1'b1;
        if (settled_q && AccReady_i) state_d = DONE;
      end
      DONE: begin
        Done_o = 1'b1;
        if (Start_i) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LoadCount_o = count_q;

endmodule
